// File: rtl/audio_framer.sv
// Audio front-end framer: per-sample DC removal / pre-emphasis, a circular sample
// buffer, and overlapping WINDOW-sample frames every HOP samples on a valid/ready stream.
module audio_framer #(
    parameter int WIDTH    = 32,
    parameter int WINDOW   = 400,
    parameter int HOP      = 160,
    parameter int DEPTH    = 1024,
    parameter int PE_SHIFT = 5,
    parameter int DC_SHIFT = 10
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid_in,
    input  logic [1:0]       mode_in,
    output logic [WIDTH-1:0] frame_data_out,
    output logic             frame_valid_out,
    input  logic             frame_ready_in,
    output logic             frame_first_out,
    output logic             frame_last_out,
    output logic             busy_out,
    output logic             overrun_out,
    output logic [15:0]      dropped_count_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WINDOW + 1);
    localparam int SW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] WIN_M1    = CW'(WINDOW - 1);
    localparam logic [CW-1:0] WIN_FULL  = CW'(WINDOW);
    localparam logic [CW-1:0] HOP_M1    = CW'(HOP - 1);
    localparam logic [AW-1:0] START_OFS = AW'(WINDOW - 1);
    localparam logic [SW-1:0] ABORT_AT  = SW'(DEPTH - WINDOW - 1);
    localparam logic [SW-1:0] SINCE_MAX = SW'(DEPTH - WINDOW);

    if (DEPTH < WINDOW + 2 * HOP) begin : g_bad_depth
        $error("audio_framer: DEPTH must be at least WINDOW + 2*HOP");
    end
    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_bad_pow2
        $error("audio_framer: DEPTH must be a power of two");
    end
    if (HOP < 1 || HOP > WINDOW) begin : g_bad_hop
        $error("audio_framer: HOP must lie in 1..WINDOW");
    end

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    // ---------------- filter stage ----------------
    logic signed [WIDTH-1:0] x_cur, d_cur, y_cur;
    logic signed [WIDTH-1:0] x1, d1;
    logic                    stg_valid;
    logic        [WIDTH-1:0] stg_data;

    // NOTE: every variable assigned in always_comb gets a value on every path (defaults first), otherwise a latch is inferred.
    always_comb begin
        x_cur = $signed(sample_in);
        d_cur = x_cur - x1 + d1 - (d1 >>> DC_SHIFT);
        case (mode_in)
            2'd1:    y_cur = x_cur - x1 + (x1 >>> PE_SHIFT);
            2'd2:    y_cur = d_cur - d1 + (d1 >>> PE_SHIFT);
            default: y_cur = x_cur;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stg_valid <= 1'b0;
            stg_data  <= '0;
            x1        <= '0;
            d1        <= '0;
        end else begin
            stg_valid <= sample_valid_in;
            if (sample_valid_in) begin
                stg_data <= y_cur;
                x1       <= x_cur;
                d1       <= d_cur;
            end
        end
    end

    // ---------------- circular buffer ----------------
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic             wr_en;

    assign wr_en = stg_valid;

    // NOTE: the sample buffer is deliberately not reset; its contents are only read after being written.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_ptr] <= stg_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
        end
    end

    // ---------------- trigger / abort decisions ----------------
    state_t        state_q, state_d;
    logic [CW-1:0] trig_cnt;
    logic          filled;
    logic [SW-1:0] since_trig;
    logic          start_pend;
    logic          trig, abort, accept, drop;

    assign trig   = wr_en && (trig_cnt == (filled ? HOP_M1 : WIN_M1));
    assign abort  = wr_en && (state_q == S_EMIT) && (since_trig == ABORT_AT);
    // A frame pending start counts as busy; an abort frees the slot for a coincident trigger.
    assign accept = trig && (abort || (state_q == S_IDLE && !start_pend));
    assign drop   = trig && !accept;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            trig_cnt   <= '0;
            filled     <= 1'b0;
            since_trig <= '0;
        end else if (wr_en) begin
            if (trig) begin
                trig_cnt <= '0;
                filled   <= 1'b1;
            end else begin
                trig_cnt <= trig_cnt + CW'(1);
            end
            if (accept) begin
                since_trig <= '0;
            end else if (since_trig != SINCE_MAX) begin
                since_trig <= since_trig + SW'(1);
            end
        end
    end

    // ---------------- frame emission FSM ----------------
    logic [AW-1:0] start_ptr, rd_ptr;
    logic [CW-1:0] rd_idx;
    logic          advance, out_xfer;
    logic          begin_frame, load, clear_out;

    assign advance  = !frame_valid_out || frame_ready_in;
    assign out_xfer = frame_valid_out && frame_ready_in;

    always_comb begin
        state_d     = state_q;
        begin_frame = 1'b0;
        load        = 1'b0;
        clear_out   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_pend) begin
                    state_d     = S_EMIT;
                    begin_frame = 1'b1;
                end
            end
            S_EMIT: begin
                if (abort || (out_xfer && frame_last_out)) begin
                    state_d   = S_IDLE;
                    clear_out = 1'b1;
                end else if (advance && rd_idx != WIN_FULL) begin
                    load = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q           <= S_IDLE;
            start_pend        <= 1'b0;
            start_ptr         <= '0;
            rd_ptr            <= '0;
            rd_idx            <= '0;
            frame_data_out    <= '0;
            frame_valid_out   <= 1'b0;
            frame_first_out   <= 1'b0;
            frame_last_out    <= 1'b0;
            overrun_out       <= 1'b0;
            dropped_count_out <= '0;
        end else begin
            state_q     <= state_d;
            overrun_out <= abort || drop;
            if ((abort || drop) && dropped_count_out != 16'hFFFF) begin
                dropped_count_out <= dropped_count_out + 16'd1;
            end

            // Frame starts at the oldest of the WINDOW samples ending with the triggering write.
            if (accept) begin
                start_pend <= 1'b1;
                start_ptr  <= wr_ptr - START_OFS;
            end else if (begin_frame) begin
                start_pend <= 1'b0;
            end

            if (begin_frame) begin
                rd_ptr <= start_ptr;
                rd_idx <= '0;
            end else if (load) begin
                rd_ptr <= rd_ptr + AW'(1);
                rd_idx <= rd_idx + CW'(1);
            end

            if (load) begin
                frame_data_out  <= mem[rd_ptr];
                frame_valid_out <= 1'b1;
                frame_first_out <= (rd_idx == '0);
                frame_last_out  <= (rd_idx == WIN_M1);
            end else if (clear_out) begin
                frame_data_out  <= '0;
                frame_valid_out <= 1'b0;
                frame_first_out <= 1'b0;
                frame_last_out  <= 1'b0;
            end
        end
    end

    assign busy_out = (state_q == S_EMIT);

endmodule

// File: tb/tb_audio_framer.sv
// Self-checking bench for audio_framer (WIDTH=16, WINDOW=8, HOP=4, DEPTH=16):
// directed scenarios plus randomized samples/modes against a queue-based reference model.
module tb_audio_framer;

    localparam int WIDTH  = 16;
    localparam int WINDOW = 8;
    localparam int HOP    = 4;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [WIDTH-1:0]  sample_in;
    logic              sample_valid_in;
    logic [1:0]        mode_in;
    logic [WIDTH-1:0]  frame_data_out;
    logic              frame_valid_out;
    logic              frame_ready_in;
    logic              frame_first_out;
    logic              frame_last_out;
    logic              busy_out;
    logic              overrun_out;
    logic [15:0]       dropped_count_out;

    audio_framer #(
        .WIDTH(WIDTH), .WINDOW(WINDOW), .HOP(HOP), .DEPTH(16), .PE_SHIFT(5), .DC_SHIFT(4)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .sample_in(sample_in),
        .sample_valid_in(sample_valid_in), .mode_in(mode_in),
        .frame_data_out(frame_data_out), .frame_valid_out(frame_valid_out),
        .frame_ready_in(frame_ready_in), .frame_first_out(frame_first_out),
        .frame_last_out(frame_last_out), .busy_out(busy_out),
        .overrun_out(overrun_out), .dropped_count_out(dropped_count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             first;
        logic             last;
    } beat_t;

    int n_vec = 0;
    int n_err = 0;
    bit rand_rdy = 1'b0;

    beat_t                    exp_q[$];
    logic [WIDTH-1:0]         hist[$];
    logic signed [WIDTH-1:0]  m_x1, m_d1;
    int                       m_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: filter equations applied to whole samples, history kept in a queue.
    task automatic model_reset();
        m_x1 = '0;
        m_d1 = '0;
        m_count = 0;
        hist.delete();
        exp_q.delete();
    endtask

    task automatic model_step(input logic [WIDTH-1:0] x, input logic [1:0] m, output bit trig);
        logic signed [WIDTH-1:0] xs, d, y;
        xs = x;
        d  = xs - m_x1 + m_d1 - (m_d1 >>> 4);
        if (m == 2'd1)      y = xs - m_x1 + (m_x1 >>> 5);
        else if (m == 2'd2) y = d - m_d1 + (m_d1 >>> 5);
        else                y = xs;
        m_x1 = xs;
        m_d1 = d;
        hist.push_back(y);
        m_count++;
        trig = (m_count >= WINDOW) && ((m_count - WINDOW) % HOP == 0);
    endtask

    task automatic push_frame();
        beat_t b;
        int n;
        n = hist.size();
        for (int i = 0; i < WINDOW; i++) begin
            b.data  = hist[n - WINDOW + i];
            b.first = (i == 0);
            b.last  = (i == WINDOW - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        if (rand_rdy) begin
            if (!frame_ready_in) frame_ready_in = 1'b1;
            else                 frame_ready_in = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] x, input logic [1:0] m, output bit trig);
        tick();
        sample_in       = x;
        mode_in         = m;
        sample_valid_in = 1'b1;
        tick();
        sample_valid_in = 1'b0;
        model_step(x, m, trig);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        sample_valid_in = 1'b0;
        tick();
        tick();
        rst_in = 1'b0;
        model_reset();
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            tick();
            t++;
        end
        check("drain_timeout", 32'(exp_q.size()), 0);
        tick();
        check("idle_valid", 32'(frame_valid_out), 0);
        check("idle_busy", 32'(busy_out), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_data"},  32'(frame_data_out), 0);
        check({tag, "_valid"}, 32'(frame_valid_out), 0);
        check({tag, "_first"}, 32'(frame_first_out), 0);
        check({tag, "_last"},  32'(frame_last_out), 0);
        check({tag, "_busy"},  32'(busy_out), 0);
        check({tag, "_ovr"},   32'(overrun_out), 0);
        check({tag, "_cnt"},   32'(dropped_count_out), 0);
    endtask

    // Scoreboard: every transfer pops one expected beat; stalled outputs must hold.
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data;
    logic             prev_first, prev_last;

    always @(negedge clk_in) begin
        if (rst_in) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && frame_valid_out) begin
                check("hold_data",  32'(frame_data_out),  32'(prev_data));
                check("hold_first", 32'(frame_first_out), 32'(prev_first));
                check("hold_last",  32'(frame_last_out),  32'(prev_last));
            end
            if (frame_valid_out && frame_ready_in) begin
                if (exp_q.size() == 0) begin
                    check("spurious_xfer", 32'(frame_valid_out), 0);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check("xfer_data",  32'(frame_data_out),  32'(b.data));
                    check("xfer_first", 32'(frame_first_out), 32'(b.first));
                    check("xfer_last",  32'(frame_last_out),  32'(b.last));
                end
            end
            prev_stall = frame_valid_out && !frame_ready_in;
            prev_data  = frame_data_out;
            prev_first = frame_first_out;
            prev_last  = frame_last_out;
        end
    end

    initial begin
        bit tr;
        rst_in          = 1'b1;
        sample_in       = '0;
        sample_valid_in = 1'b0;
        mode_in         = 2'd0;
        frame_ready_in  = 1'b1;
        repeat (3) tick();
        check_zero_outputs("reset");
        rst_in = 1'b0;
        model_reset();

        // Mode 0, samples 1..8: one frame with valid exactly 2 cycles after the 8th write.
        for (int i = 1; i <= 7; i++) send(16'(i), 2'd0, tr);
        send(16'd8, 2'd0, tr);
        push_frame();
        tick();
        check("lat_w0_valid", 32'(frame_valid_out), 0);
        tick();
        check("lat_w1_valid", 32'(frame_valid_out), 0);
        check("lat_w1_busy", 32'(busy_out), 1);
        tick();
        check("lat_w2_valid", 32'(frame_valid_out), 1);
        check("lat_w2_first", 32'(frame_first_out), 1);
        check("lat_w2_data", 32'(frame_data_out), 1);
        wait_drain();
        for (int i = 9; i <= 12; i++) send(16'(i), 2'd0, tr);
        push_frame();
        wait_drain();
        check("m0_cnt", 32'(dropped_count_out), 0);

        // Mode 1 and mode 2 with a constant input.
        do_reset();
        for (int i = 0; i < 8; i++) send(16'd1024, 2'd1, tr);
        push_frame();
        wait_drain();
        do_reset();
        for (int i = 0; i < 8; i++) send(16'd1024, 2'd2, tr);
        push_frame();
        wait_drain();

        // Ready low, samples 1..12: trigger at 12 is dropped, frame 1..8 survives.
        do_reset();
        frame_ready_in = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            send(16'(i), 2'd0, tr);
            if (i == 8) push_frame();
        end
        send(16'd12, 2'd0, tr);
        tick();
        check("drop_ovr", 32'(overrun_out), 1);
        check("drop_cnt", 32'(dropped_count_out), 1);
        tick();
        check("drop_ovr_pulse", 32'(overrun_out), 0);
        check("drop_stall_data", 32'(frame_data_out), 1);
        frame_ready_in = 1'b1;
        wait_drain();
        repeat (6) tick();
        check("drop_cnt_after", 32'(dropped_count_out), 1);

        // Ready low, samples 1..16: drop at 12, abort plus new frame at 16.
        do_reset();
        frame_ready_in = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            send(16'(i), 2'd0, tr);
            if (i == 12) begin
                tick();
                check("ab_drop_cnt", 32'(dropped_count_out), 1);
            end
        end
        send(16'd16, 2'd0, tr);
        push_frame();
        tick();
        check("ab_ovr", 32'(overrun_out), 1);
        check("ab_cnt", 32'(dropped_count_out), 2);
        check("ab_valid_low", 32'(frame_valid_out), 0);
        tick();
        check("ab_valid_low2", 32'(frame_valid_out), 0);
        tick();
        check("ab_new_valid", 32'(frame_valid_out), 1);
        check("ab_new_data", 32'(frame_data_out), 9);
        check("ab_new_first", 32'(frame_first_out), 1);
        frame_ready_in = 1'b1;
        wait_drain();
        check("ab_cnt_after", 32'(dropped_count_out), 2);

        // Reset in the middle of a stalled frame, then only 7 samples: no frame.
        do_reset();
        frame_ready_in = 1'b0;
        for (int i = 1; i <= 8; i++) send(16'(i), 2'd0, tr);
        repeat (3) tick();
        check("mid_valid", 32'(frame_valid_out), 1);
        rst_in = 1'b1;
        tick();
        check_zero_outputs("midrst");
        tick();
        rst_in = 1'b0;
        model_reset();
        frame_ready_in = 1'b1;
        for (int i = 1; i <= 7; i++) send(16'(i), 2'd0, tr);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_rst_novalid", 32'(frame_valid_out), 0);
        end
        check("post_rst_cnt", 32'(dropped_count_out), 0);
        send(16'd8, 2'd0, tr);
        push_frame();
        wait_drain();

        // Randomized samples, modes and ready, paced so every trigger yields a full frame.
        do_reset();
        rand_rdy = 1'b1;
        for (int i = 0; i < 48; i++) begin
            send(16'($urandom), 2'($urandom_range(0, 3)), tr);
            if (tr) push_frame();
            repeat (4) tick();
        end
        rand_rdy = 1'b0;
        frame_ready_in = 1'b1;
        wait_drain();
        check("rand_cnt", 32'(dropped_count_out), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/audio_framer.md
AUDIO_FRAMER -- requirements
Module: audio_framer

Interface
REQ-001 Parameter WIDTH, default 32: sample width in bits, signed two's complement.
REQ-002 Parameter WINDOW, default 400: samples per emitted frame.
REQ-003 Parameter HOP, default 160: new samples between consecutive frame starts; 1 <= HOP <= WINDOW.
REQ-004 Parameter DEPTH, default 1024: circular buffer depth, power of two; elaboration SHALL fail unless DEPTH >= WINDOW + 2*HOP.
REQ-005 Parameter PE_SHIFT, default 5: pre-emphasis coefficient 1 - 2^-PE_SHIFT.
REQ-006 Parameter DC_SHIFT, default 10: DC-removal leak 2^-DC_SHIFT.
REQ-007 clk_in  input  1  single clock; all logic on its rising edge.
REQ-008 rst_in  input  1  reset; synchronous, active-high.
REQ-009 sample_in  input  WIDTH  raw signed sample.
REQ-010 sample_valid_in  input  1  one-cycle strobe; sample_in is accepted that cycle.
REQ-011 mode_in  input  2  0 raw, 1 pre-emphasis, 2 DC removal then pre-emphasis, 3 treated as 0; sampled with each sample_valid_in.
REQ-012 frame_data_out  output  WIDTH  processed frame sample.
REQ-013 frame_valid_out / frame_ready_in  output/input  1 each  valid/ready handshake; a transfer occurs on a cycle where both are high.
REQ-014 frame_first_out, frame_last_out  output  1 each  mark the first and WINDOW-th sample of a frame; qualified by frame_valid_out.
REQ-015 busy_out  output  1  high while a frame is being emitted.
REQ-016 overrun_out  output  1  one-cycle pulse on any dropped or aborted frame.
REQ-017 dropped_count_out  output  16  count of dropped and aborted frames; saturates at 0xFFFF.

Function
REQ-018 Filter state SHALL be x1 (previous raw sample), d, d1 (current and previous DC-removed samples); all update on every accepted sample in every mode.
REQ-019 DC removal SHALL compute d = x - x1 + d1 - (d1 >>> DC_SHIFT).
REQ-020 Pre-emphasis SHALL compute y = s - s1 + (s1 >>> PE_SHIFT), with s = x in mode 1 and s = d in mode 2.
REQ-021 All arithmetic SHALL be WIDTH-bit, wrap modulo 2^WIDTH, with arithmetic right shifts; no saturation.
REQ-022 A processed sample SHALL be written to the buffer exactly 1 cycle after its sample_valid_in; the write pointer then increments modulo DEPTH.
REQ-023 A trigger SHALL occur on the write of the WINDOW-th sample after reset, and on every HOP-th write thereafter.
REQ-024 A frame SHALL consist of the WINDOW most recent processed samples at the trigger, emitted oldest first.
REQ-025 State machine IDLE -> EMIT on trigger; EMIT -> IDLE on the transfer of the frame_last_out sample or on abort.
REQ-026 frame_valid_out SHALL rise exactly 2 cycles after the triggering write.
REQ-027 Throughput SHALL be one sample per cycle while frame_ready_in is high.
REQ-028 While frame_valid_out is high and frame_ready_in is low, frame_data_out, frame_first_out and frame_last_out SHALL hold stable.
REQ-029 A trigger arriving while in EMIT SHALL be dropped: pulse overrun_out and increment dropped_count_out; the current frame continues.
REQ-030 Abort: if in EMIT and DEPTH - WINDOW samples have been written since the frame's trigger, the frame SHALL be abandoned.
REQ-031 On abort: frame_valid_out is low the next cycle, frame_last_out is never shown for that frame, overrun_out pulses and dropped_count_out increments.
REQ-032 If an abort and a trigger coincide, the abort SHALL take precedence: the count increments by 1 for the abort and the trigger starts a new frame (EMIT re-entered, per REQ-026 timing).
REQ-033 Simultaneous sample write and frame read SHALL both proceed; a write never stalls.

Reset
REQ-034 While rst_in is high, all outputs SHALL be 0, state SHALL be IDLE, and filter state, pointers, fill and hop counters and dropped_count_out SHALL clear.
REQ-035 Assertion of rst_in mid-frame SHALL abandon the frame without an overrun_out pulse; buffer contents are don't-care.
REQ-036 The first trigger after reset SHALL again require WINDOW samples.

Verification (WIDTH=16, WINDOW=8, HOP=4, DEPTH=16, PE_SHIFT=5, DC_SHIFT=4, ready high unless stated)
REQ-037 Mode 0, samples 1..8 -> one frame 1..8 (first on 1, last on 8), valid 2 cycles after the 8th write; samples 9..12 -> frame 5..12.
REQ-038 Mode 1, constant 1024 -> processed stream 1024, 32, 32, ...
REQ-039 Mode 2, constant 1024 -> processed stream 1024, -32, ...
REQ-040 Ready low, samples 1..12 -> overrun pulse at the 12th write, count=1; ready high -> intact frame 1..8, no frame 5..12.
REQ-041 Ready low, samples 1..16 -> pulse at 12 (count 1), abort plus trigger at 16 (count 2); ready high -> frame 9..16 only.
REQ-042 Reset asserted mid-frame, then samples 1..7 -> no frame, all outputs 0, count 0.
